// File: rtl/vga_ctrl_sched.sv
// vga_ctrl_sched: queues CPU cell commands and issues single-cycle cell writes to the VGA block-control port.
// Latency: a command pushed in cycle T strobes vga_ctrl_en in cycle T+2; fills stream one cell per cycle.
// Backpressure: req_ready = !fifo_full; the FIFO is not popped during a fill, so commands queue until it is full.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            command handshake (push when both high)
//   req_op/req_v/req_h/req_data    command: 0 WRITE, 1 FILL_ROW, 2 CLEAR_ALL, 3 reserved
//   vga_addr_v/_h, vga_ctrl        registered cell address and word (hold while vga_ctrl_en = 0)
//   vga_ctrl_en                    registered write strobe
//   busy                           queue non-empty, fill in progress, or strobe pending
//   err                            one-cycle pulse for each invalid command popped
//
// Build option: define VGA_SCHED_FILL_EN to compile in the row/screen fill engine.
// Without it, FILL_ROW and CLEAR_ALL are rejected as invalid commands.
module vga_ctrl_sched #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [3:0]  req_v,
    input  logic [4:0]  req_h,
    input  logic [31:0] req_data,
    output logic [3:0]  vga_addr_v,
    output logic [4:0]  vga_addr_h,
    output logic [31:0] vga_ctrl,
    output logic        vga_ctrl_en,
    output logic        busy,
    output logic        err
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] OP_WRITE     = 2'd0;
    localparam logic [1:0] OP_FILL_ROW  = 2'd1;
    localparam logic [1:0] OP_CLEAR_ALL = 2'd2;
    localparam logic [1:0] OP_RESERVED  = 2'd3;
    localparam logic [3:0] LAST_ROW     = 4'd11;

    typedef struct packed {
        logic [1:0]  op;
        logic [3:0]  v;
        logic [4:0]  h;
        logic [31:0] data;
    } cmd_t;

    // ---------------------------------------------------------------
    // Command FIFO: pointers carry one extra wrap bit to tell full from empty.
    // ---------------------------------------------------------------
    cmd_t          mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          fifo_empty, fifo_full, push, pop;
    logic          in_fill;
    cmd_t          head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign req_ready  = !fifo_full;
    assign push       = req_valid && !fifo_full;
    assign pop        = !in_fill && !fifo_empty;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{op: req_op, v: req_v, h: req_h, data: req_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Head-of-queue validation. CLEAR_ALL ignores its row field.
    // ---------------------------------------------------------------
    logic is_fill_op, cmd_invalid;

    always_comb begin
        is_fill_op  = (head.op == OP_FILL_ROW) || (head.op == OP_CLEAR_ALL);
        cmd_invalid = 1'b0;
        if (head.op == OP_RESERVED) begin
            cmd_invalid = 1'b1;
        end else if ((head.op != OP_CLEAR_ALL) && (head.v > LAST_ROW)) begin
            cmd_invalid = 1'b1;
        end
`ifndef VGA_SCHED_FILL_EN
        if (is_fill_op) cmd_invalid = 1'b1;
`endif
    end

    // ---------------------------------------------------------------
    // Fill engine: walks (cur_v, cur_h) row-major up to (last_v, 31).
    // ---------------------------------------------------------------
`ifdef VGA_SCHED_FILL_EN
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    logic [0:0]  state_q;
    logic [3:0]  cur_v_q, last_v_q;
    logic [4:0]  cur_h_q;
    logic [31:0] fill_data_q;

    assign in_fill = (state_q == ST_FILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_v_q     <= '0;
            cur_h_q     <= '0;
            last_v_q    <= '0;
            fill_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop && !cmd_invalid && is_fill_op) begin
                        cur_v_q     <= (head.op == OP_FILL_ROW) ? head.v : 4'd0;
                        last_v_q    <= (head.op == OP_FILL_ROW) ? head.v : LAST_ROW;
                        cur_h_q     <= '0;
                        fill_data_q <= head.data;
                        state_q     <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    cur_h_q <= cur_h_q + 5'd1;
                    if (cur_h_q == 5'd31) begin
                        cur_v_q <= cur_v_q + 4'd1;
                        // Leave as the final cell's write is registered so the
                        // next command pops on the following edge with no gap.
                        if (cur_v_q == last_v_q) state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
`else
    assign in_fill = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Output stage: everything to the display controller is registered.
    // ---------------------------------------------------------------
    logic        wr_en_d, err_d;
    logic [3:0]  addr_v_d;
    logic [4:0]  addr_h_d;
    logic [31:0] ctrl_d;
    logic        wr_en_q, err_q;
    logic [3:0]  addr_v_q;
    logic [4:0]  addr_h_q;
    logic [31:0] ctrl_q;

    always_comb begin
        wr_en_d  = 1'b0;
        err_d    = 1'b0;
        addr_v_d = addr_v_q;
        addr_h_d = addr_h_q;
        ctrl_d   = ctrl_q;
`ifdef VGA_SCHED_FILL_EN
        if (in_fill) begin
            wr_en_d  = 1'b1;
            addr_v_d = cur_v_q;
            addr_h_d = cur_h_q;
            ctrl_d   = fill_data_q;
        end else
`endif
        if (pop) begin
            if (cmd_invalid) begin
                err_d = 1'b1;
            end else if (head.op == OP_WRITE) begin
                wr_en_d  = 1'b1;
                addr_v_d = head.v;
                addr_h_d = head.h;
                ctrl_d   = head.data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q  <= 1'b0;
            err_q    <= 1'b0;
            addr_v_q <= '0;
            addr_h_q <= '0;
            ctrl_q   <= '0;
        end else begin
            wr_en_q  <= wr_en_d;
            err_q    <= err_d;
            addr_v_q <= addr_v_d;
            addr_h_q <= addr_h_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign vga_ctrl_en = wr_en_q;
    assign vga_addr_v  = addr_v_q;
    assign vga_addr_h  = addr_h_q;
    assign vga_ctrl    = ctrl_q;
    assign err         = err_q;
    assign busy        = !fifo_empty || in_fill || wr_en_q;

endmodule

// File: tb/tb_vga_ctrl_sched.sv
// tb_vga_ctrl_sched: directed and randomized command streams against a command-level model.
// The model expands each accepted command into its expected cell writes / error events.
// Strobes are scored in order at the falling edge; timing windows checked for gap-free runs.
module tb_vga_ctrl_sched;

`ifdef VGA_SCHED_FILL_EN
    localparam bit FILL_ON = 1'b1;
`else
    localparam bit FILL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [3:0]  req_v = '0;
    logic [4:0]  req_h = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  vga_addr_v;
    logic [4:0]  vga_addr_h;
    logic [31:0] vga_ctrl;
    logic        vga_ctrl_en;
    logic        busy;
    logic        err;

    vga_ctrl_sched #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_v(req_v), .req_h(req_h), .req_data(req_data),
        .vga_addr_v(vga_addr_v), .vga_addr_h(vga_addr_h), .vga_ctrl(vga_ctrl),
        .vga_ctrl_en(vga_ctrl_en), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_err;
        logic [3:0]  v;
        logic [4:0]  h;
        logic [31:0] d;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc      = 0;
    int  win_n = 0, win_first = 0, win_last = 0, win_exp = 0;
    int  win_err = 0, win_err_exp = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Command-level model: what the display controller should see for each accepted command.
    task automatic model_push(input logic [1:0] op, input logic [3:0] v, input logic [4:0] h,
                              input logic [31:0] d);
        bit bad;
        bad = (op == 2'd3) || (op != 2'd2 && v > 4'd11) || ((op == 2'd1 || op == 2'd2) && !FILL_ON);
        if (bad) begin
            exp_q.push_back('{is_err: 1'b1, v: 4'd0, h: 5'd0, d: 32'd0});
            win_err_exp++;
        end else if (op == 2'd0) begin
            exp_q.push_back('{is_err: 1'b0, v: v, h: h, d: d});
            win_exp++;
        end else begin
            for (int r = 0; r < 12; r++) begin
                if (op == 2'd2 || r == int'(v)) begin
                    for (int c = 0; c < 32; c++) begin
                        exp_q.push_back('{is_err: 1'b0, v: 4'(r), h: 5'(c), d: d});
                        win_exp++;
                    end
                end
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && (vga_ctrl_en || err)) begin
            if (vga_ctrl_en) begin
                if (win_n == 0) win_first = cyc;
                win_last = cyc;
                win_n++;
            end
            if (err) win_err++;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {err, vga_ctrl_en, vga_addr_v, vga_addr_h, vga_ctrl}, 64'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.is_err)
                    check("err_event", {err, vga_ctrl_en}, 2'b10);
                else
                    check("strobe", {err, vga_ctrl_en, vga_addr_v, vga_addr_h, vga_ctrl},
                          {1'b0, 1'b1, e.v, e.h, e.d});
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the command.
    task automatic push(input logic [1:0] op, input logic [3:0] v, input logic [4:0] h,
                        input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        req_op = op; req_v = v; req_h = h; req_data = d; req_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        check("push_accept", ok, 1'b1);
        @(posedge clk);
        if (ok) model_push(op, v, h, d);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin done = 1'b1; break; end
        end
        check("drain_done", done, 1'b1);
        check("drain_queue", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic win_clear();
        win_n = 0; win_exp = 0; win_err = 0; win_err_exp = 0;
    endtask

    task automatic win_check(input string tag);
        check({tag, "_count"}, win_n, win_exp);
        check({tag, "_gapless"}, win_last - win_first + 1, win_n);
        check({tag, "_errs"}, win_err, win_err_exp);
    endtask

    initial begin
        logic        exp_rdy;
        logic [1:0]  op;
        logic [3:0]  v;
        int          r, n_clear;

        // Reset values
        #12;
        check("rst_ready", req_ready, 1'b1);
        check("rst_en", vga_ctrl_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single WRITE: strobe two cycles after the push, busy drops the cycle after
        win_clear();
        push(2'd0, 4'd3, 5'd17, 32'h4100_01FF);
        @(negedge clk); check("lat_t1_en", vga_ctrl_en, 1'b0);
        @(negedge clk); check("lat_t2_en", vga_ctrl_en, 1'b1);
        check("lat_t2_busy", busy, 1'b1);
        @(negedge clk); check("after_en", vga_ctrl_en, 1'b0);
        check("busy_drop", busy, 1'b0);
        @(posedge clk); #1;
        drain();
        check("single_count", win_n, 1);

        // Backpressure: FILL_ROW then five WRITEs
        win_clear();
        push(2'd1, 4'd5, 5'd0, 32'h2A00_0007);
        for (int i = 0; i < 4; i++) push(2'd0, 4'(i), 5'(i + 3), 32'hB000_0000 + i);
        #1;
        exp_rdy = FILL_ON ? 1'b0 : 1'b1;
        check("bp_ready", req_ready, exp_rdy);
        push(2'd0, 4'd11, 5'd31, 32'hB000_00FF);
        drain();
        win_check("bp");

        // CLEAR_ALL followed by a WRITE at the origin
        win_clear();
        push(2'd2, 4'd0, 5'd0, 32'd0);
        push(2'd0, 4'd0, 5'd0, 32'h41);
        drain();
        win_check("clear");

        // Invalid commands
        win_clear();
        push(2'd3, 4'd1, 5'd1, 32'h1);
        push(2'd0, 4'd12, 5'd2, 32'h2);
        push(2'd1, 4'd2, 5'd0, 32'h3);
        drain();
        check("inv_errs", win_err, win_err_exp);
        check("inv_count", win_n, win_exp);

        // Reset in the middle of a CLEAR_ALL with three commands queued
        win_clear();
        push(2'd2, 4'd0, 5'd0, 32'hCAFE_0001);
        push(2'd0, 4'd1, 5'd1, 32'h11);
        push(2'd0, 4'd2, 5'd2, 32'h22);
        push(2'd0, 4'd3, 5'd3, 32'h33);
        if (FILL_ON) begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                @(posedge clk); #2;
                if (win_n >= 100) begin hit = 1'b1; break; end
            end
            check("mid_fill_reached", hit, 1'b1);
        end
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_outs", {vga_ctrl_en, err, busy, vga_addr_v, vga_addr_h, vga_ctrl}, 64'd0);
        check("mid_rst_ready", req_ready, 1'b1);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        win_clear();
        repeat (30) @(posedge clk);
        #2;
        check("post_rst_strobes", win_n + win_err, 0);
        check("post_rst_busy", busy, 1'b0);

        // Randomized command stream
        win_clear();
        n_clear = 0;
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 99);
            v = 4'($urandom_range(0, 11));
            if (r < 65) op = 2'd0;
            else if (r < 75) begin op = 2'd0; v = 4'($urandom_range(12, 15)); end
            else if (r < 82) op = 2'd3;
            else if (r < 97 || n_clear >= 2) op = 2'd1;
            else begin op = 2'd2; n_clear++; v = 4'($urandom_range(0, 15)); end
            push(op, v, 5'($urandom_range(0, 31)), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();
        check("rand_count", win_n, win_exp);
        check("rand_errs", win_err, win_err_exp);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
